// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module  : mem_stage_pkg
//  Purpose : Shared encodings for the memory-access stage. Contains the FSM
//            state codes, load func3 codes, writeback-select codes, store
//            byte masks, the held-op record and the small classification
//            helpers used at accept time.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;  // non-memory op held one cycle
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;  // load/store outstanding

  // Load width/sign encodings (func3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback select encodings
  localparam logic [1:0] SEL_ALU_LOAD = 2'b00;
  localparam logic [1:0] SEL_IMM      = 2'b01;
  localparam logic [1:0] SEL_PC_IMM   = 2'b10;
  localparam logic [1:0] SEL_ALU      = 2'b11;

  // Store byte masks at lane 0
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_SB   = 4'b0001;
  localparam logic [3:0] MASK_SH   = 4'b0011;
  localparam logic [3:0] MASK_SW   = 4'b1111;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] rv2;
    logic [31:0] pc_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [1:0]  reg_in_sel;
    logic [3:0]  dwe;
    logic [2:0]  func3;
    logic        mem_reg;
    logic        reg_wr;
  } ex_op_t;

  function automatic logic is_mem_op(input logic mem_reg, input logic [3:0] dwe);
    return mem_reg | (dwe != MASK_NONE);
  endfunction

  // Halfword at an odd address, or word at a non-word-aligned address.
  // Loads classify by func3 (bit 1 set means full word), stores by mask.
  function automatic logic is_misaligned(input logic       mem_reg,
                                         input logic [3:0] dwe,
                                         input logic [2:0] func3,
                                         input logic [1:0] off);
    logic half;
    logic word;
    half = mem_reg ? (func3[1:0] == 2'b01) : (dwe == MASK_SH);
    word = mem_reg ? func3[1]              : (dwe == MASK_SW);
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
//  Module  : mem_stage_if
//  Purpose : Data-memory request bus between the memory stage and the data
//            memory. Ready-based: a request is held stable until the cycle
//            in which dmem_ready is high, which completes it.
//  Ports   : master modport (stage) drives dmem_req/addr/we/wdata and
//            samples dmem_ready/rdata; slave modport (memory) is the mirror.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_we, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_we, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
//  Module  : load_align
//  Purpose : Purely combinational load extractor. Moves the addressed byte
//            or halfword down to lane 0 and sign/zero extends it per func3.
//  Ports   : rdata_i (32) load word, off_i (2) byte offset, func3_i (3)
//            width/sign; data_o (32) extended result.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = w_shifted;
    case (func3_i)
      F3_LB:   data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  data_o = {24'h0, w_shifted[7:0]};
      F3_LHU:  data_o = {16'h0, w_shifted[15:0]};
      default: data_o = w_shifted;  // all remaining codes are full word
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module  : mem_stage
//  Purpose : Memory-access pipeline stage. Holds the EX/MEM register, issues
//            lane-aligned stores and extended loads on the dmem bus, stalls
//            upstream while an access is outstanding and produces the
//            registered writeback result.
//  Ports   : clk, reset (sync, active-high)
//            in_valid/in_ready/flush  - upstream handshake and kill
//            ex_*_in                  - execute-stage results
//            dmem (mem_stage_if.master) - data memory bus
//            wb_valid/wb_rd/wb_data/wb_reg_wr - registered writeback
//            misalign_trap            - only with MEM_STAGE_MISALIGN_TRAP_EN
//  Config  : MEM_STAGE_MISALIGN_TRAP_EN - misaligned half/word accesses are
//            not issued; they complete as a trap instead.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  input  logic [31:0]  ex_alu_out_in,
  input  logic [31:0]  ex_rv2_in,
  input  logic [31:0]  ex_pc_imm_in,
  input  logic [31:0]  ex_imm_in,
  input  logic [4:0]   ex_rd_in,
  input  logic [1:0]   ex_reg_in_sel_in,
  input  logic [3:0]   ex_dwe_in,
  input  logic [2:0]   ex_func3_in,
  input  logic         ex_mem_reg_in,
  input  logic         ex_reg_wr_in,
  mem_stage_if.master  dmem,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  output logic         misalign_trap,
`endif
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_data,
  output logic         wb_reg_wr
);

  logic [1:0]  state_q, state_d;
  ex_op_t      op_q;
  logic        killed_q, killed_d;   // flush seen while the access was in flight
  logic        trap_q;               // held op is a misaligned access

  ex_op_t      w_in_op;
  logic        w_in_mem;
  logic        w_in_trap;
  logic        w_accept;
  logic        w_mem_done;
  logic        w_complete;
  logic        w_wb_fire;
  logic        w_issue;
  logic        w_is_load;
  logic        w_is_store;
  logic [1:0]  w_off;
  logic [3:0]  w_we_shift;
  logic [31:0] w_load_data;
  logic [31:0] w_sel_data;
  logic [31:0] w_wb_data;

  assign w_in_op = '{alu_out:    ex_alu_out_in,
                     rv2:        ex_rv2_in,
                     pc_imm:     ex_pc_imm_in,
                     imm:        ex_imm_in,
                     rd:         ex_rd_in,
                     reg_in_sel: ex_reg_in_sel_in,
                     dwe:        ex_dwe_in,
                     func3:      ex_func3_in,
                     mem_reg:    ex_mem_reg_in,
                     reg_wr:     ex_reg_wr_in};

  assign w_in_mem = is_mem_op(ex_mem_reg_in, ex_dwe_in);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_in_trap = w_in_mem &
                     is_misaligned(ex_mem_reg_in, ex_dwe_in, ex_func3_in, ex_alu_out_in[1:0]);
`else
  assign w_in_trap = 1'b0;
`endif

  // ---- handshake -----------------------------------------------------------
  assign w_mem_done = (state_q == ST_MEM_WAIT) & dmem.dmem_ready;
  assign w_complete = (state_q == ST_HOLD) | w_mem_done;
  assign in_ready   = !flush & ((state_q == ST_EMPTY) | (state_q == ST_HOLD) | w_mem_done);
  assign w_accept   = in_valid & in_ready;
  // A flushed access still runs to dmem_ready but must not write back.
  assign w_wb_fire  = w_complete & !flush & !killed_q;

  // ---- dmem bus ------------------------------------------------------------
  assign w_is_load  = op_q.mem_reg;
  assign w_is_store = !op_q.mem_reg & (op_q.dwe != MASK_NONE);
  assign w_off      = op_q.alu_out[1:0];
  // Reset gates the bus so a dropped request is never seen by the memory.
  assign w_issue    = (state_q == ST_MEM_WAIT) & !reset;

  // Lanes shifted past byte 3 fall off the top.
  always_comb begin
    w_we_shift = op_q.dwe;
    case (w_off)
      2'd1:    w_we_shift = {op_q.dwe[2:0], 1'b0};
      2'd2:    w_we_shift = {op_q.dwe[1:0], 2'b00};
      2'd3:    w_we_shift = {op_q.dwe[0], 3'b000};
      default: w_we_shift = op_q.dwe;
    endcase
  end

  assign dmem.dmem_req   = w_issue;
  assign dmem.dmem_addr  = w_issue ? {op_q.alu_out[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_we    = (w_issue & w_is_store) ? w_we_shift : 4'h0;
  assign dmem.dmem_wdata = (w_issue & w_is_store) ? (op_q.rv2 << {w_off, 3'b000}) : 32'h0;

  load_align u_load_align (
    .rdata_i (dmem.dmem_rdata),
    .off_i   (w_off),
    .func3_i (op_q.func3),
    .data_o  (w_load_data)
  );

  // ---- writeback select ----------------------------------------------------
  always_comb begin
    w_sel_data = op_q.alu_out;
    case (op_q.reg_in_sel)
      SEL_IMM:    w_sel_data = op_q.imm;
      SEL_PC_IMM: w_sel_data = op_q.pc_imm;
      default:    w_sel_data = op_q.alu_out;
    endcase
  end

  assign w_wb_data = ((state_q == ST_MEM_WAIT) & w_is_load) ? w_load_data : w_sel_data;

  // ---- next state ----------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (w_accept) begin
      state_d = (w_in_mem & !w_in_trap) ? ST_MEM_WAIT : ST_HOLD;
    end else if (w_complete | (flush & (state_q != ST_MEM_WAIT))) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    killed_d = killed_q;
    if (w_accept | w_complete) begin
      killed_d = 1'b0;
    end else if ((state_q == ST_MEM_WAIT) & flush) begin
      killed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      op_q      <= '0;
      killed_q  <= 1'b0;
      trap_q    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0;
      wb_reg_wr <= 1'b0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      if (w_accept) begin
        op_q   <= w_in_op;
        trap_q <= w_in_trap;
      end
      // Only wb_valid drops between results; the data fields hold.
      wb_valid <= w_wb_fire;
      if (w_wb_fire) begin
        wb_rd     <= op_q.rd;
        wb_data   <= w_wb_data;
        wb_reg_wr <= op_q.reg_wr & !w_is_store & !trap_q;
      end
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= w_wb_fire & trap_q;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module  : tb_mem_stage
//  Purpose : Self-checking bench for mem_stage. Directed stimulus pushes
//            expected writebacks and expected dmem requests into queues;
//            a writeback monitor and a memory model pop and compare.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush;
  logic [31:0] ex_alu_out_in, ex_rv2_in, ex_pc_imm_in, ex_imm_in;
  logic [4:0]  ex_rd_in;
  logic [1:0]  ex_reg_in_sel_in;
  logic [3:0]  ex_dwe_in;
  logic [2:0]  ex_func3_in;
  logic        ex_mem_reg_in, ex_reg_wr_in;
  logic        wb_valid, wb_reg_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .flush            (flush),
    .ex_alu_out_in    (ex_alu_out_in),
    .ex_rv2_in        (ex_rv2_in),
    .ex_pc_imm_in     (ex_pc_imm_in),
    .ex_imm_in        (ex_imm_in),
    .ex_rd_in         (ex_rd_in),
    .ex_reg_in_sel_in (ex_reg_in_sel_in),
    .ex_dwe_in        (ex_dwe_in),
    .ex_func3_in      (ex_func3_in),
    .ex_mem_reg_in    (ex_mem_reg_in),
    .ex_reg_wr_in     (ex_reg_wr_in),
    .dmem             (dmem_bus.master),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misalign_trap    (misalign_trap),
`endif
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .wb_reg_wr        (wb_reg_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        reg_wr;
    logic        trap;
    bit          chk_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    bit          is_store;
    int          wait_cyc;
    logic [31:0] rdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  int       wb_cyc[$];
  int       n_cmp = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       wait_cnt = 0;
  wb_exp_t  mon_e;
  bus_exp_t mem_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- writeback monitor ---------------------------------------------------
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d, expected no writeback (t=%0t)", wb_rd, $time);
      end else begin
        mon_e = wb_q.pop_front();
        chk("wb_rd", {27'h0, wb_rd}, {27'h0, mon_e.rd});
        chk("wb_reg_wr", {31'h0, wb_reg_wr}, {31'h0, mon_e.reg_wr});
        if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk("misalign_trap", {31'h0, misalign_trap}, {31'h0, mon_e.trap});
`endif
        wb_cyc.push_back(cyc);
      end
    end
  end

  // ---- data memory model + request checker ---------------------------------
  initial begin
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (dmem_bus.dmem_ready) begin
      dmem_bus.dmem_ready = 1'b0;
      wait_cnt = 0;
    end
    if (dmem_bus.dmem_req === 1'b1) begin
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_req: got dmem_req=1 addr=0x%08h, expected no request (t=%0t)",
                 dmem_bus.dmem_addr, $time);
        dmem_bus.dmem_ready = 1'b1;
      end else begin
        mem_e = bus_q[0];
        chk("dmem_addr", dmem_bus.dmem_addr, mem_e.addr);
        chk("dmem_we", {28'h0, dmem_bus.dmem_we}, {28'h0, mem_e.we});
        if (mem_e.is_store) chk("dmem_wdata", dmem_bus.dmem_wdata, mem_e.wdata);
        if (wait_cnt >= mem_e.wait_cyc) begin
          dmem_bus.dmem_ready = 1'b1;
          dmem_bus.dmem_rdata = mem_e.rdata;
          void'(bus_q.pop_front());
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---- stimulus helpers ----------------------------------------------------
  task automatic set_op(input logic [31:0] alu, input logic [31:0] rv2,
                        input logic [31:0] pcimm, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [1:0] sel,
                        input logic [3:0] dwe, input logic [2:0] f3,
                        input logic memr, input logic regwr);
    ex_alu_out_in = alu;  ex_rv2_in = rv2;  ex_pc_imm_in = pcimm;  ex_imm_in = imm;
    ex_rd_in = rd;  ex_reg_in_sel_in = sel;  ex_dwe_in = dwe;  ex_func3_in = f3;
    ex_mem_reg_in = memr;  ex_reg_wr_in = regwr;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic accept();
    bit ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] imm,
                        input logic [31:0] pcimm, input logic [4:0] rd, input logic [31:0] exp);
    set_op(alu, 32'h0, pcimm, imm, rd, sel, MASK_NONE, 3'b000, 1'b0, 1'b1);
    wb_q.push_back('{rd: rd, data: exp, reg_wr: 1'b1, trap: 1'b0, chk_data: 1'b1});
    accept();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] rv2, input logic [3:0] dwe,
                       input logic [4:0] rd, input logic [31:0] exp_addr,
                       input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    set_op(addr, rv2, 32'h0, 32'h0, rd, SEL_ALU_LOAD, dwe, 3'b010, 1'b0, 1'b1);
    bus_q.push_back('{addr: exp_addr, we: exp_we, wdata: exp_wdata, is_store: 1'b1,
                      wait_cyc: 0, rdata: 32'h0});
    wb_q.push_back('{rd: rd, data: 32'h0, reg_wr: 1'b0, trap: 1'b0, chk_data: 1'b0});
    accept();
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                      input int waitc, input logic [4:0] rd, input logic [31:0] exp_addr,
                      input logic [31:0] exp, input bit exp_wb);
    set_op(addr, 32'h0, 32'h0, 32'h0, rd, SEL_ALU_LOAD, MASK_NONE, f3, 1'b1, 1'b1);
    bus_q.push_back('{addr: exp_addr, we: 4'h0, wdata: 32'h0, is_store: 1'b0,
                      wait_cyc: waitc, rdata: rdata});
    if (exp_wb) wb_q.push_back('{rd: rd, data: exp, reg_wr: 1'b1, trap: 1'b0, chk_data: 1'b1});
    accept();
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (wb_q.size() == 0 && bus_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d wb and %0d bus entries pending, expected 0",
               wb_q.size(), bus_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---- directed sequence ---------------------------------------------------
  initial begin
    int base;
    reset = 1'b1;  in_valid = 1'b0;  flush = 1'b0;
    set_op(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 4'h0, 3'b000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_reg_wr", {31'h0, wb_reg_wr}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_bus.dmem_req}, 32'h0);
    chk("rst_dmem_addr", dmem_bus.dmem_addr, 32'h0);
    chk("rst_dmem_we", {28'h0, dmem_bus.dmem_we}, 32'h0);
    chk("rst_dmem_wdata", dmem_bus.dmem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Three back-to-back non-memory ops, then an sel=11 op
    base = wb_cyc.size();
    alu_op(SEL_ALU_LOAD, 32'h0000_1234, 32'h0,         32'h0,         5'd5, 32'h0000_1234);
    alu_op(SEL_IMM,      32'h0000_0001, 32'hDEAD_BEEF, 32'h0,         5'd1, 32'hDEAD_BEEF);
    alu_op(SEL_PC_IMM,   32'h0000_0002, 32'h0,         32'h0040_0010, 5'd2, 32'h0040_0010);
    drain();
    if (wb_cyc.size() >= base + 3) begin
      chk("b2b_gap1", wb_cyc[base+1] - wb_cyc[base], 32'd1);
      chk("b2b_gap2", wb_cyc[base+2] - wb_cyc[base+1], 32'd1);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL b2b_count: got %0d writebacks, expected 3", wb_cyc.size() - base);
    end
    alu_op(SEL_ALU, 32'h0000_0055, 32'h1111_1111, 32'h2222_2222, 5'd3, 32'h0000_0055);
    drain();

    // Stores: lane shift and truncation
    store(32'h0000_0103, 32'h1234_56AB, MASK_SB, 5'd7, 32'h0000_0100, 4'b1000, 32'hAB00_0000);
    store(32'h0000_0102, 32'h0000_BEEF, MASK_SH, 5'd7, 32'h0000_0100, 4'b1100, 32'hBEEF_0000);
    store(32'h0000_0200, 32'hCAFE_F00D, MASK_SW, 5'd7, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
    drain();

    // Loads: extract and extend
    load(32'h0000_0102, F3_LB,  32'h0080_0000, 0, 5'd8, 32'h0000_0100, 32'hFFFF_FF80, 1'b1);
    load(32'h0000_0102, F3_LBU, 32'h0080_0000, 0, 5'd8, 32'h0000_0100, 32'h0000_0080, 1'b1);
    load(32'h0000_0102, F3_LH,  32'h8001_0000, 1, 5'd8, 32'h0000_0100, 32'hFFFF_8001, 1'b1);
    load(32'h0000_0102, F3_LHU, 32'h8001_0000, 0, 5'd8, 32'h0000_0100, 32'h0000_8001, 1'b1);
    drain();

    // LW with three wait cycles: stall and completion timing
    load(32'h0000_0200, F3_LW, 32'h1122_3344, 3, 5'd9, 32'h0000_0200, 32'h1122_3344, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("wait_in_ready", {31'h0, in_ready}, 32'h0);
      chk("wait_dmem_req", {31'h0, dmem_bus.dmem_req}, 32'h1);
    end
    @(negedge clk); #1;
    chk("done_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk); #1;
    chk("lw_wb_valid", {31'h0, wb_valid}, 32'h1);
    drain();

    // Flush during the wait: access completes, no writeback
    load(32'h0000_0300, F3_LW, 32'h9999_9999, 3, 5'd12, 32'h0000_0300, 32'h0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    chk("hold_wb_data", wb_data, 32'h1122_3344);
    chk("hold_wb_rd", {27'h0, wb_rd}, 32'd9);

    // Flush while a non-memory op is held
    set_op(32'h0000_0077, 32'h0, 32'h0, 32'h0, 5'd4, SEL_ALU, MASK_NONE, 3'b000, 1'b0, 1'b1);
    accept();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();

    // Flush together with in_valid: not accepted
    set_op(32'h0000_0088, 32'h0, 32'h0, 32'h0, 5'd6, SEL_ALU, MASK_NONE, 3'b000, 1'b0, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk); #1;
    chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    drain();

    // Reset in the middle of an outstanding access
    load(32'h0000_0400, F3_LW, 32'h5555_5555, 6, 5'd11, 32'h0000_0400, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_req", {31'h0, dmem_bus.dmem_req}, 32'h0);
    chk("rst_mid_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
    drain();

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // Misaligned word load: trapped, never issued
    set_op(32'h0000_0102, 32'h0, 32'h0, 32'h0, 5'd10, SEL_ALU_LOAD, MASK_NONE, F3_LW, 1'b1, 1'b1);
    wb_q.push_back('{rd: 5'd10, data: 32'h0, reg_wr: 1'b0, trap: 1'b1, chk_data: 1'b0});
    accept();
    @(negedge clk); #1;
    chk("trap_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("trap_pulse", {31'h0, misalign_trap}, 32'h1);
    @(negedge clk); #1;
    chk("trap_clear", {31'h0, misalign_trap}, 32'h0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
